// File: rtl/multiplier_pkg.sv
// multiplier_pkg
//   Shared definitions for the shift-and-add multiplier: the default
//   operand width and the controller state encoding.
package multiplier_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multiplier_datapath.sv
// mult_datapath
//   Radix-2 shift-and-add datapath. It holds the zero-extended
//   multiplicand, the multiplier, the accumulator and the iteration
//   counter, and advances one partial product per step.
// Ports
//   clk      : rising-edge clock
//   rst_i    : synchronous active-high clear of all registers
//   load_i   : capture operands, clear accumulator and counter
//   step_i   : perform one iteration
//   a_i      : multiplicand (WIDTH bits, unsigned)
//   b_i      : multiplier   (WIDTH bits, unsigned)
//   acc_sum_o: accumulator plus the current partial product
//   last_o   : the iteration in progress is the final one
module mult_datapath
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_sum_o,
  output logic               last_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] addend;

  assign addend    = mplier_q[0] ? mcand_q : '0;
  // The product of two WIDTH-bit values fits in 2*WIDTH bits, so the
  // running sum can never carry out.
  assign acc_sum_o = acc_q + addend;
  assign last_o    = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_sum_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/multiplier.sv
// multiplier
//   Sequential unsigned multiplier, one partial product per clock.
//   A start sampled in IDLE loads the operands; WIDTH cycles later the
//   product is registered and done rises. done stays high until start
//   is released, so a held start never launches a second operation.
// Ports
//   clk     : rising-edge clock
//   reset_n : synchronous reset, ACTIVE HIGH despite the name
//   start   : operation request, level-sampled in IDLE
//   data1   : multiplicand (WIDTH bits, unsigned)
//   data2   : multiplier   (WIDTH bits, unsigned)
//   product : registered 2*WIDTH-bit result
//   done    : result valid, held while in DONE
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | waiting for start; operands captured when it is seen
// CALC    | one shift-and-add iteration per cycle, WIDTH cycles
// DONE    | product valid; waits for start to drop
module multiplier
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;
  logic               load, step, last;
  logic [2*WIDTH-1:0] acc_sum;

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst_i     (reset_n),
    .load_i    (load),
    .step_i    (step),
    .a_i       (data1),
    .b_i       (data2),
    .acc_sum_o (acc_sum),
    .last_o    (last)
  );

  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    done_d    = done_q;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          load    = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        // The final iteration's sum goes straight into product so the
        // result lands on the same edge that finishes the last step.
        if (last) begin
          product_d = acc_sum;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        if (!start) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q   <= ST_IDLE;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign done    = done_q;

endmodule

// File: tb/tb_multiplier.sv
module tb_multiplier;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  data1;
  logic [7:0]  data2;
  logic [15:0] product;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_prod;

  multiplier #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .data1   (data1),
    .data2   (data2),
    .product (product),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, measure latency, check the held product and
  // optionally disturb the operands while the calculation runs.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit scramble);
    int n;
    data1 = a;
    data2 = b;
    start = 1'b1;
    tick();
    if (scramble) begin
      data1 = ~a;
      data2 = ~b;
    end
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (n == 4) begin
        chk({tag, "_midprod"}, {16'd0, product}, {16'd0, prev_prod});
        chk({tag, "_middone"}, {31'd0, done}, 32'd0);
      end
      if (done) break;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_prod"}, {16'd0, product}, {16'd0, exp});
    prev_prod = exp;
  endtask

  task automatic drop_start(input string tag);
    start = 1'b0;
    tick();
    chk({tag, "_donefall"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold"}, {16'd0, product}, {16'd0, prev_prod});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b1;
    start     = 1'b1;
    data1     = 8'h1A;
    data2     = 8'h2D;
    prev_prod = 16'd0;

    for (int i = 0; i < 5; i++) tick();
    chk("rst_prod", {16'd0, product}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b0;

    run_op("m26x45", 8'h1A, 8'h2D, 16'd1170, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("m26x45_holddone", {31'd0, done}, 32'd1);
      chk("m26x45_holdprod", {16'd0, product}, 32'd1170);
    end
    drop_start("m26x45");

    run_op("m100x179", 8'h64, 8'hB3, 16'd17900, 1'b0);
    drop_start("m100x179");

    run_op("m199x49", 8'hC7, 8'h31, 16'd9751, 1'b0);
    drop_start("m199x49");
    run_op("m199x57", 8'hC7, 8'h39, 16'd11343, 1'b0);
    drop_start("m199x57");

    run_op("m255x255", 8'hFF, 8'hFF, 16'd65025, 1'b0);
    drop_start("m255x255");

    run_op("m0x200", 8'h00, 8'hC8, 16'd0, 1'b0);
    drop_start("m0x200");

    run_op("m26x45_scr", 8'h1A, 8'h2D, 16'd1170, 1'b1);
    drop_start("m26x45_scr");

    // Abort at iteration 4 with a nonzero product already registered.
    data1 = 8'hFF;
    data2 = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    chk("abort_prod", {16'd0, product}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_late_prod", {16'd0, product}, 32'd0);
    chk("abort_late_done", {31'd0, done}, 32'd0);
    prev_prod = 16'd0;

    run_op("m18x52", 8'h12, 8'h34, 16'd936, 1'b0);
    drop_start("m18x52");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
